line_mem_responder: RTL and testbench

- Synthesizable memory-side responder for the 128-bit cache-line refill/writeback protocol used by the D-cache and the read-only I-cache.
- Accepts one line request at a time, waits a programmable latency, then completes it with a one-cycle `mem_ready` pulse.
- Backs the requests with an on-chip line array.
- Replaces the behavioural slow-memory models, so the full CHIP plus memory can be synthesized and emulated.
- One instance per memory port: I-side and D-side.

---
 rtl/line_mem_responder_pkg.sv | 22 ++
 rtl/line_mem_responder_if.sv | 29 ++
 rtl/line_mem_responder_ram.sv | 34 +++
 rtl/line_mem_responder.sv | 126 ++++++++++++
 tb/tb_line_mem_responder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for the cache-line memory responder.
// Contents: line/address geometry, FSM state encoding and request op encoding.
package mem_if_pkg;

  localparam int LINE_W  = 128;
  localparam int ADDR_HI = 31;
  localparam int ADDR_LO = 4;
  localparam int MEM_AW  = ADDR_HI - ADDR_LO + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/line_mem_responder_if.sv
// Cache <-> memory line refill/writeback bus.
// master: the cache (drives requests); slave: the memory responder.
//   mem_read/mem_write  request strobes, held until after mem_ready
//   mem_addr            line address (byte address [31:4])
//   mem_wdata           write line data
//   mem_rdata           read line data, valid while mem_ready is high
//   mem_ready           one-cycle completion strobe
//   proto_err           sticky "read and write requested together" flag
interface line_mem_if;
  import mem_if_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              proto_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, proto_err
  );
endinterface

// File: rtl/line_mem_responder_ram.sv
// Single-port 2^AW x DW synchronous RAM with registered read.
// Kept as its own block so it can be replaced by an SRAM macro.
//   clk, rst_n  clock and async active-low reset (read register only)
//   en_rd       load rdata from mem[addr] on the rising edge
//   en_wr       write wdata into mem[addr] on the rising edge
//   addr        line index
//   wdata       write data
//   rdata       registered read data, holds between reads
module line_ram_1rw #(
  parameter int AW = 8,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_rd,
  input  logic          en_wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (en_wr) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (en_rd) rdata <= mem[addr];
  end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the 128-bit cache-line protocol.
// Accepts one request at a time, waits LATENCY cycles, then pulses mem_ready.
//   clk    system clock
//   rst_n  async active-low reset
//   bus    line_mem_if slave port (requests in, data/ready/proto_err out)
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; captures the request
// BUSY  | counting down the remaining latency
// RESP  | mem_ready high; read data valid, write commits on exit
// HOLD  | one dead cycle while the cache drops its request
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LINE_AW = 8,
  parameter int LATENCY = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  line_mem_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("line_mem_responder: LATENCY must be 1..255");
  end

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t               state, state_nxt;
  logic [7:0]           cnt, cnt_nxt;
  op_t                  req_op;
  logic [LINE_AW-1:0]   req_idx;
  logic [LINE_W-1:0]    req_wdata;
  logic                 proto_err_q;
  logic                 accept;
  logic                 ram_rd, ram_wr;
  logic [LINE_AW-1:0]   ram_addr;
  logic [LINE_AW-1:0]   in_idx;

  // Upper line-address bits alias modulo the array depth.
  assign in_idx = bus.mem_addr[LINE_AW-1:0];

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The RAM read is launched on the edge entering RESP so the registered
  // data lines up with mem_ready.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = req_idx;
    case (state)
      IDLE: begin
        ram_addr = in_idx;
        if (bus.mem_read || bus.mem_write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            cnt_nxt   = '0;
            ram_rd    = !bus.mem_write;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_nxt = RESP;
          ram_rd    = (req_op == OP_RD);
        end
      end
      RESP: begin
        ram_wr    = (req_op == OP_WR);
        state_nxt = HOLD;
      end
      HOLD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_op      <= OP_RD;
      req_idx     <= '0;
      req_wdata   <= '0;
      proto_err_q <= 1'b0;
    end else if (accept) begin
      req_op    <= bus.mem_write ? OP_WR : OP_RD;
      req_idx   <= in_idx;
      req_wdata <= bus.mem_wdata;
      if (bus.mem_read && bus.mem_write) proto_err_q <= 1'b1;
    end
  end

  line_ram_1rw #(
    .AW (LINE_AW),
    .DW (LINE_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en_rd (ram_rd),
    .en_wr (ram_wr),
    .addr  (ram_addr),
    .wdata (req_wdata),
    .rdata (bus.mem_rdata)
  );

  assign bus.mem_ready = (state == RESP);
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_line_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_mem_if m4();
  line_mem_if m1();

  line_mem_responder #(.LINE_AW(8), .LATENCY(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m4)
  );

  line_mem_responder #(.LINE_AW(8), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m1)
  );

  int n_chk = 0;
  int n_pass = 0;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
  localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
  localparam logic [127:0] D4 = 128'h00FF00FF_00FF00FF_F0F0F0F0_0F0F0F0F;
  localparam logic [127:0] D5 = 128'h55555555_AAAAAAAA_13579BDF_2468ACE0;
  localparam logic [127:0] DA = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] DB = 128'h99999999_88888888_77777777_66666666;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [27:0] addr, input logic [127:0] wd);
    if (sel) begin
      m1.mem_read = rd; m1.mem_write = wr; m1.mem_addr = addr; m1.mem_wdata = wd;
    end else begin
      m4.mem_read = rd; m4.mem_write = wr; m4.mem_addr = addr; m4.mem_wdata = wd;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? m1.mem_ready : m4.mem_ready;
  endfunction

  function automatic logic [127:0] get_rdata(input bit sel);
    return sel ? m1.mem_rdata : m4.mem_rdata;
  endfunction

  // Drives a request, counts cycles until mem_ready (1 = first cycle after
  // the accepting edge), then returns the bus to IDLE.
  task automatic do_xfer(input bit sel, input bit rd, input bit wr,
                         input logic [27:0] addr, input logic [127:0] wd,
                         input bit churn,
                         output logic [127:0] rdat, output int lat);
    drive(sel, rd, wr, addr, wd);
    @(posedge clk); #1;
    lat = 1;
    while (!get_ready(sel) && lat < 64) begin
      if (churn)
        drive(sel, rd, wr, 28'($urandom), {$urandom, $urandom, $urandom, $urandom});
      @(posedge clk); #1;
      lat++;
    end
    rdat = get_rdata(sel);
    drive(sel, 1'b0, 1'b0, '0, '0);
    @(posedge clk); @(posedge clk); #1;
  endtask

  logic [127:0] rdat;
  int lat;

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready4", m4.mem_ready, 1'b0);
    check_val("rst_rdata4", m4.mem_rdata, '0);
    check_val("rst_perr4",  m4.proto_err, 1'b0);
    check_val("rst_ready1", m1.mem_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write then read, LATENCY=4
    do_xfer(1'b0, 1'b0, 1'b1, 28'h0000010, D1, 1'b0, rdat, lat);
    check_val("wr_lat4", 128'(lat), 128'd4);
    check_val("wr_rdata_held", rdat, '0);
    do_xfer(1'b0, 1'b1, 1'b0, 28'h0000010, '0, 1'b0, rdat, lat);
    check_val("rd_lat4", 128'(lat), 128'd4);
    check_val("rd_data", rdat, D1);

    // aliasing modulo 256 lines
    do_xfer(1'b0, 1'b0, 1'b1, 28'h0000105, D2, 1'b0, rdat, lat);
    check_val("alias_wr_rdata_held", rdat, D1);
    do_xfer(1'b0, 1'b1, 1'b0, 28'h0000005, '0, 1'b0, rdat, lat);
    check_val("alias_rd_data", rdat, D2);

    // LATENCY=1
    do_xfer(1'b1, 1'b0, 1'b1, 28'h0000007, D3, 1'b0, rdat, lat);
    check_val("wr_lat1", 128'(lat), 128'd1);
    do_xfer(1'b1, 1'b1, 1'b0, 28'h0000007, '0, 1'b0, rdat, lat);
    check_val("rd_lat1", 128'(lat), 128'd1);
    check_val("rd_data1", rdat, D3);

    // LATENCY=1 with mem_read held: one pulse per RESP/HOLD/IDLE round
    drive(1'b1, 1'b1, 1'b0, 28'h0000007, '0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("hold_ready_%0d", i), m1.mem_ready, (i % 3 == 0));
      if (i % 3 == 0) check_val($sformatf("hold_rdata_%0d", i), m1.mem_rdata, D3);
      if (i == 5) drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
    end
    check_val("hold_quiet", m1.mem_ready, 1'b0);
    @(posedge clk); #1;

    // input churn during BUSY
    do_xfer(1'b0, 1'b0, 1'b1, 28'h0000033, D4, 1'b1, rdat, lat);
    check_val("churn_wr_lat", 128'(lat), 128'd4);
    do_xfer(1'b0, 1'b1, 1'b0, 28'h0000033, '0, 1'b1, rdat, lat);
    check_val("churn_rd_data", rdat, D4);

    // read+write together: write wins, sticky proto_err
    check_val("perr_before", m4.proto_err, 1'b0);
    do_xfer(1'b0, 1'b1, 1'b1, 28'h0000044, D5, 1'b0, rdat, lat);
    check_val("perr_lat", 128'(lat), 128'd4);
    check_val("perr_rdata_held", rdat, D4);
    check_val("perr_set", m4.proto_err, 1'b1);
    do_xfer(1'b0, 1'b1, 1'b0, 28'h0000044, '0, 1'b0, rdat, lat);
    check_val("perr_rd_data", rdat, D5);
    check_val("perr_sticky", m4.proto_err, 1'b1);

    // reset during BUSY of a write must not commit it
    do_xfer(1'b0, 1'b0, 1'b1, 28'h0000020, DA, 1'b0, rdat, lat);
    drive(1'b0, 1'b0, 1'b1, 28'h0000020, DB);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_ready_a", m4.mem_ready, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("abort_ready_%0d", i), m4.mem_ready, 1'b0);
    end
    check_val("abort_perr_clr", m4.proto_err, 1'b0);
    check_val("abort_rdata_clr", m4.mem_rdata, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("abort_ready_post", m4.mem_ready, 1'b0);
    do_xfer(1'b0, 1'b1, 1'b0, 28'h0000020, '0, 1'b0, rdat, lat);
    check_val("abort_rd_lat", 128'(lat), 128'd4);
    check_val("abort_rd_data", rdat, DA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // mem_ready must never be high in two consecutive cycles
  logic prev4 = 1'b0, prev1 = 1'b0;
  always @(negedge clk) begin
    if (prev4 && m4.mem_ready) check_val("back2back4", 1'b1, 1'b0);
    if (prev1 && m1.mem_ready) check_val("back2back1", 1'b1, 1'b0);
    prev4 = m4.mem_ready;
    prev1 = m1.mem_ready;
  end

endmodule
